// File: rtl/serv_ctrl_wide_pkg.sv
// Shared definitions for the digit-serial PC unit: FSM states and W helpers.
package serv_ctrl_wide_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFetch  = 2'd1,
        StUpdate = 2'd2
    } state_e;

    function automatic bit w_is_legal(input int unsigned w);
        return (w == 1) || (w == 2) || (w == 4) || (w == 8);
    endfunction

    function automatic int unsigned log2_w(input int unsigned w);
        case (w)
            2:       return 1;
            4:       return 2;
            8:       return 3;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/serv_ctrl_wide_shift_reg.sv
// Digit-serial shift register: W-bit digit enters at the MSB end, LSB digit and full word out.
module serv_ctrl_wide_shift_reg #(
    parameter int unsigned    LEN  = 32,
    parameter int unsigned    W    = 1,
    parameter logic [LEN-1:0] INIT = '0
) (
    input  logic           clk,
    input  logic           i_rst,
    input  logic           en_i,
    input  logic [W-1:0]   d_i,
    output logic [W-1:0]   q_o,
    output logic [LEN-1:0] par_o
);
    logic [LEN-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (en_i) begin
            sr_d = {d_i, sr_q[LEN-1:W]};
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            sr_q <= INIT;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q_o   = sr_q[W-1:0];
    assign par_o = sr_q;

endmodule

// File: rtl/serv_ctrl_wide.sv
// PC and control-transfer unit processing one W-bit digit per cycle.
// Define SERV_CTRL_RVC_EN for compressed support (+2 increment/link, bit-1 targets legal).
module serv_ctrl_wide
    import serv_ctrl_wide_pkg::*;
#(
    parameter int unsigned W        = 1,
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter bit          WITH_CSR = 1'b1
) (
    input  logic         clk,
    input  logic         i_rst,
    input  logic         i_pc_en,
    input  logic [4:0]   i_cnt,
    input  logic         i_jump,
    input  logic         i_jal_or_jalr,
    input  logic         i_utype,
    input  logic         i_pc_rel,
    input  logic         i_trap,
    input  logic         i_iscomp,
    input  logic [W-1:0] i_imm,
    input  logic [W-1:0] i_buf,
    input  logic [W-1:0] i_csr_pc,
    output logic [W-1:0] o_rd,
    output logic         o_bad_pc,
    output logic [31:0]  o_ibus_adr,
    output logic         o_ibus_cyc,
    input  logic         i_ibus_ack
);
    localparam int unsigned Lw = log2_w(W);

    if (!w_is_legal(W)) begin : g_bad_w
        $error("serv_ctrl_wide: W must be 1, 2, 4 or 8");
    end

    state_e       state_q, state_d;
    logic         acc_q, acc_d;
    logic         carry_inc_q, carry_inc_d;
    logic         carry_off_q, carry_off_d;
    logic         comp;
    logic [4:0]   inc_bit;
    logic [W-1:0] pc_digit, inc, imm_mask, offset_a, offset_b;
    logic [W-1:0] pc_plus_inc, pc_plus_off, target, new_digit;
    logic         cin_inc, cin_off, cout_inc, cout_off;

    serv_ctrl_wide_shift_reg #(
        .LEN  (32),
        .W    (W),
        .INIT (RESET_PC)
    ) u_pc (
        .clk   (clk),
        .i_rst (i_rst),
        .en_i  (i_pc_en),
        .d_i   (new_digit),
        .q_o   (pc_digit),
        .par_o (o_ibus_adr)
    );

    // Only the digit holding the increment bit adds a non-zero value.
    assign inc_bit = comp ? 5'd1 : 5'd2;
    always_comb begin
        inc = '0;
        if ((i_cnt >> Lw) == (inc_bit >> Lw)) begin
            inc = W'(1) << (inc_bit & 5'(W - 1));
        end
    end

    for (genvar k = 0; k < W; k++) begin : g_mask
        assign imm_mask[k] = ({1'b0, i_cnt} + 6'(k)) >= 6'd12;
    end

    assign offset_a = i_pc_rel ? pc_digit : '0;
    assign offset_b = i_utype ? (i_imm & imm_mask) : i_buf;

    assign cin_inc = (i_cnt == 5'd0) ? 1'b0 : carry_inc_q;
    assign cin_off = (i_cnt == 5'd0) ? 1'b0 : carry_off_q;
    assign {cout_inc, pc_plus_inc} = {1'b0, pc_digit} + {1'b0, inc} + {{W{1'b0}}, cin_inc};
    assign {cout_off, pc_plus_off} = {1'b0, offset_a} + {1'b0, offset_b} + {{W{1'b0}}, cin_off};

    assign carry_inc_d = i_pc_en ? cout_inc : carry_inc_q;
    assign carry_off_d = i_pc_en ? cout_off : carry_off_q;

    // Target only passes once a fetch has been accepted; bit 0 is always cleared (JALR rule).
    always_comb begin
        target = i_jump ? pc_plus_off : pc_plus_inc;
        if (WITH_CSR && i_trap) begin
            target = i_csr_pc;
        end
        new_digit = acc_q ? target : '0;
        if (i_cnt == 5'd0) begin
            new_digit[0] = 1'b0;
        end
    end

    assign o_rd = ({W{i_utype}} & pc_plus_off) | ({W{i_jal_or_jalr}} & pc_plus_inc);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        if (i_pc_en) begin
            state_d = StUpdate;
        end else begin
            case (state_q)
                StFetch: begin
                    if (i_ibus_ack) begin
                        state_d = StIdle;
                        acc_d   = 1'b1;
                    end
                end
                StUpdate: begin
                    state_d = StFetch;
                    acc_d   = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_ibus_cyc = (state_q == StFetch);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q     <= StFetch;
            acc_q       <= 1'b0;
            carry_inc_q <= 1'b0;
            carry_off_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            carry_inc_q <= carry_inc_d;
            carry_off_q <= carry_off_d;
        end
    end

`ifdef SERV_CTRL_RVC_EN
    assign comp     = i_iscomp;
    assign o_bad_pc = 1'b0;
`else
    localparam logic [4:0]  Bit1Cnt = 5'((1 >> Lw) << Lw);
    localparam int unsigned Bit1Pos = 1 % W;

    logic bad_q, bad_d;
    logic unused_iscomp;

    assign comp          = 1'b0;
    assign unused_iscomp = i_iscomp;

    always_comb begin
        bad_d = bad_q;
        if (i_pc_en) begin
            if (i_cnt == 5'd0) begin
                bad_d = 1'b0;
            end
            if (i_jump && (i_cnt == Bit1Cnt) && new_digit[Bit1Pos]) begin
                bad_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            bad_q <= 1'b0;
        end else begin
            bad_q <= bad_d;
        end
    end

    assign o_bad_pc = bad_q;
`endif

endmodule
